pa_in_fifo: RTL and testbench

Parallel-input capture block: samples an 8-bit pin bus on a strobe and pushes each sample into a small FIFO that the CPU drains over the bus. It is the receive direction of the existing FIFO-to-parallel-output LED path, and sits between a GPIO input port and the CPU/DMA read interface. It provides level, full/empty and a sticky overflow flag so firmware can tell whether any samples were lost.

---
 rtl/pa_in_fifo.sv | 137 +++++++++++++
 tb/tb_pa_in_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_in_fifo.sv
// pa_in_fifo: parallel-input capture FIFO.
// Samples a WIDTH-bit pin bus (after a 2-flop synchronizer) on sample_tick and
// queues each sample in a DEPTH-entry show-ahead FIFO drained by rd_req.
// Optional build macro: PA_IN_CHANGE_ONLY_EN -- when defined, a tick only
// queues a sample that differs from the last accepted one (the first sample
// after reset is always queued).
//
// Handshake semantics: rd_data always shows the head entry (0 when empty).
// A pop happens on a rising edge where rd_req=1 and empty=0; rd_req while
// empty is ignored. A tick write is taken when not full, or when full and a
// pop happens on the same edge; otherwise the sample is dropped and the sticky
// overflow flag is set.
module pa_in_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           pins_in,
  input  logic                       sample_tick,
  input  logic                       rd_req,
  input  logic                       ovf_clr,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drq,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] HALF_L  = LW'(DEPTH / 2);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [LW-1:0]    count;

  logic wr_req;
  logic wr_acc;
  logic rd_acc;
  logic drop;

  // Two-stage synchronizer for the asynchronous pin bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins_in;
      sync2 <= sync1;
    end
  end

`ifdef PA_IN_CHANGE_ONLY_EN
  logic [WIDTH-1:0] last_sample;
  logic             seen;

  // Remember the last accepted sample; a dropped sample leaves this alone so
  // the next tick retries it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_sample <= '0;
      seen        <= 1'b0;
    end else if (wr_acc) begin
      last_sample <= sync2;
      seen        <= 1'b1;
    end
  end

  // Only request a write when the synchronized value changed.
  always_comb begin
    wr_req = sample_tick && (!seen || (sync2 != last_sample));
  end
`else
  // Every tick requests a write.
  always_comb begin
    wr_req = sample_tick;
  end
`endif

  // Status flags and accept/drop decisions, all from the registered count.
  always_comb begin
    empty    = (count == '0);
    full     = (count == DEPTH_L);
    level    = count;
    drq      = (count >= HALF_L);
    rd_acc   = rd_req && !empty;
    wr_acc   = wr_req && (!full || rd_req);
    drop     = wr_req && full && !rd_req;
    rd_data  = empty ? '0 : mem[rp];
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wp] <= sync2;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        wp <= wp + 1'b1;
      end
      if (rd_acc) begin
        rp <= rp + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a drop on the same edge as a clear leaves it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pa_in_fifo.sv
// tb_pa_in_fifo: directed bench for pa_in_fifo with an expected-data queue
// filled by the stimulus tasks and drained by a pop monitor.
module tb_pa_in_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] pins_in;
  logic             sample_tick;
  logic             rd_req;
  logic             ovf_clr;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [2:0]       level;
  logic             drq;
  logic             overflow;

  logic [WIDTH-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  pa_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .pins_in     (pins_in),
    .sample_tick (sample_tick),
    .rd_req      (rd_req),
    .ovf_clr     (ovf_clr),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .drq         (drq),
    .overflow    (overflow)
  );

  // Clock generation.
  always #5 clock = ~clock;

  // Pop monitor: whenever a pop will be taken on the next edge, the head
  // entry must match the oldest expected sample.
  always @(negedge clock) begin
    if (!reset && rd_req && !empty) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_data: unexpected pop, rd_data=%02h, expected queue empty", rd_data);
      end else begin
        logic [WIDTH-1:0] exp_v;
        exp_v = exp_q.pop_front();
        if (rd_data !== exp_v) begin
          miscompares++;
          $display("FAIL pop_data: got %02h, expected %02h", rd_data, exp_v);
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clock);
  endtask

  // Present val on the pins for two edges, then tick on the third.
  // stored says whether the hand-derived model expects it to be queued.
  task automatic capture(input logic [WIDTH-1:0] val, input bit stored, input bit with_pop);
    pins_in = val;
    step();
    step();
    sample_tick = 1'b1;
    rd_req      = with_pop;
    if (stored) exp_q.push_back(val);
    step();
    sample_tick = 1'b0;
    rd_req      = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    pins_in     = '0;
    sample_tick = 1'b0;
    rd_req      = 1'b0;
    ovf_clr     = 1'b0;
    step();
    step();

    // Reset values.
    sample_point();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_drq", drq, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_data", rd_data, 8'h00);
    reset = 1'b0;
    step();

    // Idle pins with no ticks.
    pins_in = 8'hA5;
    for (int i = 0; i < 10; i++) step();
    pins_in = 8'h00;
    sample_point();
    check("idle_empty", empty, 1);
    check("idle_level", level, 0);
    check("idle_rd_data", rd_data, 8'h00);
    check("idle_overflow", overflow, 0);

    // Basic capture and ordered drain.
    capture(8'h11, 1, 0);
    sample_point();
    check("cap1_level", level, 1);
    check("cap1_rd_data", rd_data, 8'h11);
    check("cap1_drq", drq, 0);
    capture(8'h22, 1, 0);
    capture(8'h33, 1, 0);
    sample_point();
    check("cap3_level", level, 3);
    check("cap3_drq", drq, 1);
    pop();
    sample_point();
    check("pop1_level", level, 2);
    check("pop1_drq", drq, 1);
    pop();
    sample_point();
    check("pop2_level", level, 1);
    check("pop2_drq", drq, 0);
    pop();
    sample_point();
    check("pop3_level", level, 0);
    check("pop3_empty", empty, 1);
    // Read on empty is ignored and raises nothing.
    pop();
    sample_point();
    check("rd_empty_level", level, 0);
    check("rd_empty_overflow", overflow, 0);

    // Overflow: fifth sample dropped.
    for (int v = 1; v <= 5; v++) capture(8'(v), v <= 4, 0);
    sample_point();
    check("ovf_full", full, 1);
    check("ovf_level", level, 4);
    check("ovf_overflow", overflow, 1);
    for (int i = 0; i < 4; i++) pop();
    sample_point();
    check("ovf_drained", empty, 1);
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    sample_point();
    check("ovf_clr", overflow, 0);

    // Full with simultaneous pop and tick: the write is taken.
    for (int v = 8'h41; v <= 8'h44; v++) capture(8'(v), 1, 0);
    capture(8'h77, 1, 1);
    sample_point();
    check("fullrw_level", level, 4);
    check("fullrw_overflow", overflow, 0);
    check("fullrw_head", rd_data, 8'h42);
    for (int i = 0; i < 4; i++) pop();
    sample_point();
    check("fullrw_empty", empty, 1);

    // Tick and read on empty: write stored, read ignored.
    capture(8'h66, 1, 1);
    sample_point();
    check("emptyrw_level", level, 1);
    check("emptyrw_rd_data", rd_data, 8'h66);
    pop();

    // Reset mid-fill.
    capture(8'h01, 1, 0);
    capture(8'h02, 1, 0);
    capture(8'h03, 1, 0);
    sample_point();
    check("midrst_pre_level", level, 3);
    do_reset();
    sample_point();
    check("midrst_empty", empty, 1);
    check("midrst_level", level, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_rd_data", rd_data, 8'h00);
    capture(8'h5A, 1, 0);
    sample_point();
    check("midrst_cap_level", level, 1);
    check("midrst_cap_data", rd_data, 8'h5A);
    pop();

    // Change-only sequence from a fresh reset.
    do_reset();
`ifdef PA_IN_CHANGE_ONLY_EN
    capture(8'h00, 1, 0);
    capture(8'h00, 0, 0);
    capture(8'h3C, 1, 0);
    capture(8'h3C, 0, 0);
    capture(8'h00, 1, 0);
    sample_point();
    check("chg_level", level, 3);
    check("chg_overflow", overflow, 0);
    for (int i = 0; i < 3; i++) pop();
`else
    capture(8'h00, 1, 0);
    capture(8'h00, 1, 0);
    capture(8'h3C, 1, 0);
    capture(8'h3C, 1, 0);
    capture(8'h00, 0, 0);
    sample_point();
    check("chg_level", level, 4);
    check("chg_overflow", overflow, 1);
    for (int i = 0; i < 4; i++) pop();
`endif
    sample_point();
    check("final_empty", empty, 1);
    check("final_queue_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
